// File: rtl/ext_arbiter_pkg.sv
// Shared constants and types for the extender arbiter: EOp encodings,
// requester ids and the output-buffer state type.
package ext_arbiter_pkg;

    localparam logic [1:0] EOP_SIGN     = 2'b00;
    localparam logic [1:0] EOP_ZERO     = 2'b01;
    localparam logic [1:0] EOP_LUI      = 2'b10;
    localparam logic [1:0] EOP_SIGN_SL2 = 2'b11;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic {
        StEmpty,
        StFull
    } buf_state_e;

endpackage

// File: rtl/ext_arbiter_ext.sv
// Immediate extender: widens a 16-bit immediate to 32 bits according to EOp.
module ext
    import ext_arbiter_pkg::*;
(
    input  logic [15:0] imm,
    input  logic [1:0]  eop,
    output logic [31:0] res
);

    always_comb begin
        res = '0;
        case (eop)
            EOP_SIGN:     res = {{16{imm[15]}}, imm};
            EOP_ZERO:     res = {16'h0000, imm};
            EOP_LUI:      res = {imm, 16'h0000};
            EOP_SIGN_SL2: res = {{14{imm[15]}}, imm, 2'b00};
            default:      res = '0;
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester arbiter in front of one shared immediate extender, with a
// one-entry valid/ready result buffer and saturating per-requester grant counters.
module ext_arbiter
    import ext_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [15:0]      req0_imm,
    input  logic [1:0]       req0_eop,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_imm,
    input  logic [1:0]       req1_eop,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    buf_state_e       state_q, state_d;
    logic             last_grant_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_id_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic [15:0]      ext_imm;
    logic [1:0]       ext_eop;
    logic [31:0]      ext_res;

    assign can_accept = (state_q == StEmpty) || rsp_ready;

    // Gating with reset keeps both readys low during any reset cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_REQ0;
        if (reset && can_accept) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = (FIXED_PRI != 0) ? ID_REQ0 : ~last_grant_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = ID_REQ0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ID_REQ1;
            end
        end
    end

    assign req0_ready = grant_valid && (grant_id == ID_REQ0);
    assign req1_ready = grant_valid && (grant_id == ID_REQ1);

    assign ext_imm = (grant_id == ID_REQ1) ? req1_imm : req0_imm;
    assign ext_eop = (grant_id == ID_REQ1) ? req1_eop : req0_eop;

    ext u_ext (
        .imm (ext_imm),
        .eop (ext_eop),
        .res (ext_res)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (grant_valid) state_d = StFull;
            end
            StFull: begin
                if (!grant_valid && rsp_ready) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == StFull);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_data_q   <= '0;
            rsp_id_q     <= ID_REQ0;
            last_grant_q <= ID_REQ1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else if (grant_valid) begin
            rsp_data_q   <= ext_res;
            rsp_id_q     <= grant_id;
            last_grant_q <= grant_id;
            if (grant_id == ID_REQ0 && cnt0_q != {CNT_W{1'b1}}) cnt0_q <= cnt0_q + 1'b1;
            if (grant_id == ID_REQ1 && cnt1_q != {CNT_W{1'b1}}) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: three configurations (round-robin, fixed priority, 2-bit
// counters) driven by directed and random stimulus against a behavioural model.
module tb_ext_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r0v [3];
    logic        r1v [3];
    logic        r0r [3];
    logic        r1r [3];
    logic        rv  [3];
    logic        rid [3];
    logic        rr  [3];
    logic [15:0] r0i [3];
    logic [15:0] r1i [3];
    logic [1:0]  r0e [3];
    logic [1:0]  r1e [3];
    logic [31:0] rd  [3];
    logic [15:0] c0_0, c1_0, c0_1, c1_1;
    logic [1:0]  c0_2, c1_2;

    ext_arbiter #(.FIXED_PRI(0), .CNT_W(16)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[0]), .req0_imm(r0i[0]), .req0_eop(r0e[0]), .req0_ready(r0r[0]),
        .req1_valid(r1v[0]), .req1_imm(r1i[0]), .req1_eop(r1e[0]), .req1_ready(r1r[0]),
        .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_id(rid[0]), .rsp_ready(rr[0]),
        .cnt0(c0_0), .cnt1(c1_0)
    );

    ext_arbiter #(.FIXED_PRI(1), .CNT_W(16)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[1]), .req0_imm(r0i[1]), .req0_eop(r0e[1]), .req0_ready(r0r[1]),
        .req1_valid(r1v[1]), .req1_imm(r1i[1]), .req1_eop(r1e[1]), .req1_ready(r1r[1]),
        .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_id(rid[1]), .rsp_ready(rr[1]),
        .cnt0(c0_1), .cnt1(c1_1)
    );

    ext_arbiter #(.FIXED_PRI(0), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset),
        .req0_valid(r0v[2]), .req0_imm(r0i[2]), .req0_eop(r0e[2]), .req0_ready(r0r[2]),
        .req1_valid(r1v[2]), .req1_imm(r1i[2]), .req1_eop(r1e[2]), .req1_ready(r1r[2]),
        .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_id(rid[2]), .rsp_ready(rr[2]),
        .cnt0(c0_2), .cnt1(c1_2)
    );

    // Reference model state, one slot per instance.
    bit          m_full [3];
    logic [31:0] m_data [3];
    bit          m_id   [3];
    bit          m_last [3];
    int          m_c0   [3];
    int          m_c1   [3];
    int          cmax   [3] = '{65535, 65535, 3};
    bit          fixed  [3] = '{1'b0, 1'b1, 1'b0};
    bit          p_g0   [3];
    bit          p_g1   [3];
    bit          got0   [3];
    bit          got1   [3];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] eop);
        int sx = int'($signed(imm));
        int zx = int'(imm);
        case (eop)
            2'd0:    return sx;
            2'd1:    return zx;
            2'd2:    return zx * 65536;
            default: return sx * 4;
        endcase
    endfunction

    function automatic int cnt_of(input int k, input bit which);
        case (k)
            0:       return which ? int'(c1_0) : int'(c0_0);
            1:       return which ? int'(c1_1) : int'(c0_1);
            default: return which ? int'(c1_2) : int'(c0_2);
        endcase
    endfunction

    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            p_g0[k] = 1'b0;
            p_g1[k] = 1'b0;
            if (reset && (!m_full[k] || rr[k])) begin
                if (r0v[k] && r1v[k]) begin
                    // Round-robin: whoever did not win last time.
                    if (fixed[k] || m_last[k]) p_g0[k] = 1'b1;
                    else p_g1[k] = 1'b1;
                end else begin
                    p_g0[k] = r0v[k];
                    p_g1[k] = r1v[k];
                end
            end
            got0[k] = r0r[k];
            got1[k] = r1r[k];
            check($sformatf("ready0[%0d]", k), 32'(r0r[k]), 32'(p_g0[k]));
            check($sformatf("ready1[%0d]", k), 32'(r1r[k]), 32'(p_g1[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_full[k] = 1'b0; m_data[k] = '0; m_id[k] = 1'b0;
                m_last[k] = 1'b1; m_c0[k] = 0;   m_c1[k] = 0;
            end else if (p_g0[k] || p_g1[k]) begin
                m_full[k] = 1'b1;
                m_id[k]   = p_g1[k];
                m_last[k] = p_g1[k];
                m_data[k] = p_g1[k] ? model_ext(r1i[k], r1e[k]) : model_ext(r0i[k], r0e[k]);
                if (p_g0[k] && m_c0[k] < cmax[k]) m_c0[k]++;
                if (p_g1[k] && m_c1[k] < cmax[k]) m_c1[k]++;
            end else if (m_full[k] && rr[k]) begin
                m_full[k] = 1'b0;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rsp_valid[%0d]", k), 32'(rv[k]), 32'(m_full[k]));
            if (m_full[k]) begin
                check($sformatf("rsp_data[%0d]", k), rd[k], m_data[k]);
                check($sformatf("rsp_id[%0d]", k), 32'(rid[k]), 32'(m_id[k]));
            end
            check($sformatf("cnt0[%0d]", k), cnt_of(k, 1'b0), m_c0[k]);
            check($sformatf("cnt1[%0d]", k), cnt_of(k, 1'b1), m_c1[k]);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            r0v[k] = 1'b0;
            r1v[k] = 1'b0;
            rr[k]  = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            r0i[k] = '0; r1i[k] = '0; r0e[k] = '0; r1e[k] = '0;
        end
        @(negedge clk);
        r0v[0] = 1'b1;
        step();
        step();
        check("reset_valid", 32'(rv[0]), 32'd0);
        check("reset_ready0", 32'(got0[0]), 32'd0);
        reset = 1'b1;

        // req0 alone, LUI-style extension
        idle();
        r0v[0] = 1'b1; r0i[0] = 16'hf111; r0e[0] = 2'b10;
        step();
        check("t1_ready", 32'(got0[0]), 32'd1);
        check("t1_valid", 32'(rv[0]), 32'd1);
        check("t1_data", rd[0], 32'hf1110000);
        check("t1_id", 32'(rid[0]), 32'd0);
        check("t1_cnt0", 32'(c0_0), 32'd1);

        // Round-robin alternation from a fresh reset
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        r0v[0] = 1'b1; r0i[0] = 16'h8000; r0e[0] = 2'b00;
        r1v[0] = 1'b1; r1i[0] = 16'h8000; r1e[0] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_grant0", 32'(got0[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_data", rd[0], (i % 2 == 0) ? 32'hffff8000 : 32'h00008000);
        end
        check("t2_cnt0", 32'(c0_0), 32'd2);
        check("t2_cnt1", 32'(c1_0), 32'd2);

        // Backpressure holds the buffer and blocks new grants
        idle();
        r1v[0] = 1'b1; r1i[0] = 16'hffff; r1e[0] = 2'b11;
        step();
        idle();
        r0v[0] = 1'b1; r0i[0] = 16'h0001; r0e[0] = 2'b00; rr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_data", rd[0], 32'hfffffffc);
            check("t3_hold_ready", 32'(got0[0]), 32'd0);
        end
        rr[0] = 1'b1;
        step();
        check("t3_release_ready", 32'(got0[0]), 32'd1);
        check("t3_release_data", rd[0], 32'h00000001);

        // Fixed priority: req0 always wins
        idle();
        r0v[1] = 1'b1; r0i[1] = 16'h1234; r0e[1] = 2'b01;
        r1v[1] = 1'b1; r1i[1] = 16'h4321; r1e[1] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_ready1", 32'(got1[1]), 32'd0);
        end
        check("t4_cnt0", 32'(c0_1), 32'd3);
        check("t4_cnt1", 32'(c1_1), 32'd0);

        // Counter saturation with 2-bit counters
        idle();
        r0v[2] = 1'b1; r0i[2] = 16'h0042; r0e[2] = 2'b00;
        for (int i = 0; i < 5; i++) step();
        check("t5_sat", 32'(c0_2), 32'd3);

        // Reset while FULL
        idle();
        r0v[0] = 1'b1; r0i[0] = 16'h00aa; r0e[0] = 2'b01;
        step();
        idle();
        rr[0] = 1'b0;
        reset = 1'b0;
        step();
        check("t6_valid", 32'(rv[0]), 32'd0);
        check("t6_cnt0", 32'(c0_0), 32'd0);
        check("t6_cnt1", 32'(c1_0), 32'd0);
        reset = 1'b1;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        step();
        check("t6_first_tie", 32'(got0[0]), 32'd1);

        // Random traffic on all three configurations
        idle();
        for (int k = 0; k < 3; k++) begin
            p_g0[k] = 1'b0;
            p_g1[k] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!r0v[k] || p_g0[k]) begin
                    r0v[k] = ($urandom_range(0, 2) != 0);
                    r0i[k] = 16'($urandom);
                    r0e[k] = 2'($urandom);
                end
                if (!r1v[k] || p_g1[k]) begin
                    r1v[k] = ($urandom_range(0, 2) != 0);
                    r1i[k] = 16'($urandom);
                    r1e[k] = 2'($urandom);
                end
                rr[k] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
